fd_pipe_bank: RTL and testbench

- Parametrised successor to the single-bit iCE40UP enable/local-set-reset flip-flop model.
- Provides a WIDTH-bit, DEPTH-stage register pipeline with clock enable, a local set/reset with selectable priority, and per-stage valid tracking with an occupancy count.
- Used as a generic retiming/delay-line primitive in SoM datapaths (sensor pixel paths, CDC-free alignment delays).
- Simulation-behavioural, but fully synthesisable.

---
 rtl/fd_pipe_bank.sv | 89 ++++++++
 tb/tb_fd_pipe_bank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fd_pipe_bank.sv
// WIDTH-bit, DEPTH-stage enabled register pipeline with local set/reset, per-stage valid
// bits and an occupancy count. Generic retiming / alignment delay line.
module fd_pipe_bank #(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      DEPTH  = 3,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter logic [WIDTH-1:0] LSRVAL = '0,
    parameter string            SRMODE = "CE_OVER_LSR",
    parameter int unsigned      OCCW   = $clog2(DEPTH + 1)
) (
    input  logic             CK,
    input  logic             SRN,
    input  logic             SP,
    input  logic             LSR,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic [OCCW-1:0]  OCC
);

    localparam bit LsrOverCe = (SRMODE == "LSR_OVER_CE");

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "fd_pipe_bank: WIDTH must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "fd_pipe_bank: DEPTH must be at least 1");
    end
    if ((SRMODE != "CE_OVER_LSR") && (SRMODE != "LSR_OVER_CE")) begin : g_bad_mode
        $fatal(1, "fd_pipe_bank: SRMODE must be CE_OVER_LSR or LSR_OVER_CE");
    end

    logic [WIDTH-1:0] r_q [DEPTH] = '{default: INIT};
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] v_q = '0;
    logic [DEPTH-1:0] v_d;
    logic [OCCW-1:0]  occ_q = '0;
    logic [OCCW-1:0]  occ_d;
    logic [WIDTH-1:0] d_clean;
    logic             dv_clean;
    logic             lsr_hit;

    always_comb begin
        // Anything that is not a clean 1 (X, Z) is captured as 0.
        for (int i = 0; i < int'(WIDTH); i++) begin
            d_clean[i] = (D[i] === 1'b1);
        end
        dv_clean = (DV === 1'b1);
        lsr_hit  = LSR && (SP || LsrOverCe);

        r_d   = r_q;
        v_d   = v_q;
        occ_d = occ_q;
        if (lsr_hit) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_d[i] = LSRVAL;
            end
            v_d   = '0;
            occ_d = '0;
        end else if (SP) begin
            r_d[0] = d_clean;
            v_d[0] = dv_clean;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_d[i] = r_q[i-1];
                v_d[i] = v_q[i-1];
            end
            // A valid leaving and one entering in the same cycle cancel out.
            occ_d = occ_q + OCCW'(dv_clean) - OCCW'(v_q[DEPTH-1]);
        end
    end

    always_ff @(posedge CK) begin
        if (!SRN) begin
            r_q   <= '{default: INIT};
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            r_q   <= r_d;
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    assign Q   = r_q[DEPTH-1];
    assign QV  = v_q[DEPTH-1];
    assign OCC = occ_q;

endmodule

// File: tb/tb_fd_pipe_bank.sv
// Bench for fd_pipe_bank: three instances (CE_OVER_LSR depth 3, LSR_OVER_CE depth 3,
// CE_OVER_LSR depth 4) share one stimulus stream.
module tb_fd_pipe_bank;

    logic       clk = 1'b0;
    logic       srn, sp, lsr, dv;
    logic [7:0] d;
    logic [7:0] qa, qb, qc;
    logic       qva, qvb, qvc;
    logic [1:0] occa, occb;
    logic [2:0] occc;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fd_pipe_bank #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5), .LSRVAL(8'hFF), .SRMODE("CE_OVER_LSR"))
    u_a (.CK(clk), .SRN(srn), .SP(sp), .LSR(lsr), .D(d), .DV(dv), .Q(qa), .QV(qva), .OCC(occa));

    fd_pipe_bank #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5), .LSRVAL(8'h3C), .SRMODE("LSR_OVER_CE"))
    u_b (.CK(clk), .SRN(srn), .SP(sp), .LSR(lsr), .D(d), .DV(dv), .Q(qb), .QV(qvb), .OCC(occb));

    fd_pipe_bank #(.WIDTH(8), .DEPTH(4), .INIT(8'h00), .LSRVAL(8'h00), .SRMODE("CE_OVER_LSR"))
    u_c (.CK(clk), .SRN(srn), .SP(sp), .LSR(lsr), .D(d), .DV(dv), .Q(qc), .QV(qvc), .OCC(occc));

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } sb_t;

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       exp_qv;
        logic [7:0] exp_q;
        logic [2:0] exp_occ;
    } vec_t;

    sb_t  sbq[$];
    sb_t  exp_e;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enabled shift on u_a; the word popped from the scoreboard is what Q must show.
    task automatic shift_a(input logic [7:0] din, input logic vin, input logic [1:0] exp_occ);
        sp  = 1'b1;
        d   = din;
        dv  = vin;
        sbq.push_back('{data: din, valid: vin});
        step();
        exp_e = sbq.pop_front();
        chk("shift_q", 32'(qa), 32'(exp_e.data));
        chk("shift_qv", 32'(qva), 32'(exp_e.valid));
        chk("shift_occ", 32'(occa), 32'(exp_occ));
    endtask

    initial begin
        vt[0] = '{1'b1, 8'h10, 1'b0, 8'h00, 3'd1};
        vt[1] = '{1'b0, 8'h11, 1'b0, 8'h00, 3'd1};
        vt[2] = '{1'b1, 8'h12, 1'b0, 8'h00, 3'd2};
        vt[3] = '{1'b1, 8'h13, 1'b1, 8'h10, 3'd3};
        vt[4] = '{1'b0, 8'h14, 1'b0, 8'h11, 3'd2};
        vt[5] = '{1'b0, 8'h15, 1'b1, 8'h12, 3'd2};
        vt[6] = '{1'b0, 8'h16, 1'b1, 8'h13, 3'd1};
        vt[7] = '{1'b0, 8'h17, 1'b0, 8'h14, 3'd0};

        srn = 1'b0;
        sp  = 1'b1;
        lsr = 1'b0;
        dv  = 1'b0;
        d   = 8'h00;
        #1;
        chk("powerup_q", 32'(qa), 32'hA5);
        chk("powerup_occ", 32'(occa), 32'h0);

        // Reset held for two edges with live data on the inputs.
        d  = 8'h77;
        dv = 1'b1;
        step();
        step();
        chk("reset_q", 32'(qa), 32'hA5);
        chk("reset_qv", 32'(qva), 32'h0);
        chk("reset_occ", 32'(occa), 32'h0);
        chk("reset_qc", 32'(qc), 32'h00);
        chk("reset_occc", 32'(occc), 32'h0);

        // Fill: pipeline holds INIT/invalid until the first word has crossed all stages.
        srn = 1'b1;
        sbq.push_back('{data: 8'hA5, valid: 1'b0});
        sbq.push_back('{data: 8'hA5, valid: 1'b0});
        shift_a(8'h11, 1'b1, 2'd1);
        shift_a(8'h22, 1'b1, 2'd2);
        shift_a(8'h33, 1'b1, 2'd3);
        shift_a(8'h44, 1'b1, 2'd3);

        // Stall with changing data: everything frozen.
        sp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d  = 8'hC0 + 8'(i);
            dv = 1'b1;
            step();
            chk("stall_q", 32'(qa), 32'(exp_e.data));
            chk("stall_qv", 32'(qva), 32'(exp_e.valid));
            chk("stall_occ", 32'(occa), 32'h3);
        end
        shift_a(8'h55, 1'b1, 2'd3);
        shift_a(8'h66, 1'b1, 2'd3);
        shift_a(8'h77, 1'b1, 2'd3);

        // LSR with SP=0: ignored in CE_OVER_LSR, honoured in LSR_OVER_CE.
        sp  = 1'b0;
        lsr = 1'b1;
        step();
        chk("ce_lsr_hold_q", 32'(qa), 32'(exp_e.data));
        chk("ce_lsr_hold_occ", 32'(occa), 32'h3);
        chk("lsr_ce_q", 32'(qb), 32'h3C);
        chk("lsr_ce_qv", 32'(qvb), 32'h0);
        chk("lsr_ce_occ", 32'(occb), 32'h0);
        sp = 1'b1;
        step();
        chk("ce_lsr_q", 32'(qa), 32'hFF);
        chk("ce_lsr_qv", 32'(qva), 32'h0);
        chk("ce_lsr_occ", 32'(occa), 32'h0);
        lsr = 1'b0;

        // Valid bubbles through the depth-4 instance.
        srn = 1'b0;
        step();
        srn = 1'b1;
        sp  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d  = vt[i].d;
            dv = vt[i].dv;
            step();
            chk("bubble_q", 32'(qc), 32'(vt[i].exp_q));
            chk("bubble_qv", 32'(qvc), 32'(vt[i].exp_qv));
            chk("bubble_occ", 32'(occc), 32'(vt[i].exp_occ));
        end

        // Unknown bits are captured as zero.
        d  = 8'bxxxx_0101;
        dv = 1'b1;
        step();
        d  = 8'h00;
        dv = 1'b0;
        step();
        step();
        chk("sanitise_q", 32'(qa), 32'h05);
        chk("sanitise_qv", 32'(qva), 32'h1);

        // SRN wins over an active local reset.
        srn = 1'b0;
        lsr = 1'b1;
        sp  = 1'b1;
        d   = 8'h99;
        dv  = 1'b1;
        step();
        chk("srn_over_lsr_q", 32'(qa), 32'hA5);
        chk("srn_over_lsr_qv", 32'(qva), 32'h0);
        chk("srn_over_lsr_occ", 32'(occa), 32'h0);
        chk("srn_over_lsr_qb", 32'(qb), 32'hA5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
